// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM among several glyph-row requesters.
// Requester 0 may take strict priority, the others rotate round-robin; grants are tracked to the ROM return.
module font_rom_arbiter #(
  parameter int REQ_CNT     = 4,
  parameter int A_WIDTH     = 13,
  parameter int D_WIDTH     = 16,
  parameter int ROM_LATENCY = 1,
  parameter int PRIO0       = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REQ_CNT-1:0]         req_i,
  input  logic [REQ_CNT*A_WIDTH-1:0] addr_i,
  output logic [REQ_CNT-1:0]         gnt_o,
  output logic [A_WIDTH-1:0]         rom_addr_o,
  input  logic [D_WIDTH-1:0]         rom_data_i,
  output logic [REQ_CNT-1:0]         rd_valid_o,
  output logic [D_WIDTH-1:0]         rd_data_o,
  output logic [CNT_WIDTH-1:0]       deny_cnt_o
);

  localparam int PW = $clog2(REQ_CNT);

  logic [PW-1:0]        r_rr_ptr;
  logic [A_WIDTH-1:0]   r_addr_hold;
  logic [CNT_WIDTH-1:0] r_deny_cnt;
  logic [REQ_CNT-1:0]   r_vld [ROM_LATENCY];

  logic [REQ_CNT-1:0]   w_gnt;
  logic [PW-1:0]        w_gnt_idx;
  logic [PW-1:0]        w_idx;
  logic                 w_any_gnt;
  logic                 w_rr_gnt;
  logic [A_WIDTH-1:0]   w_gnt_addr;
  logic                 w_deny;

  // Grant selection: priority for requester 0, else rotating search after rr_ptr
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_any_gnt = 1'b0;
    w_rr_gnt  = 1'b0;
    if (!rst_n) begin
      w_any_gnt = 1'b0;
    end else if (PRIO0 != 0 && req_i[0]) begin
      w_any_gnt = 1'b1;
      w_gnt_idx = '0;
    end else begin
      for (int i = 1; i <= REQ_CNT; i++) begin
        w_idx = PW'((int'(r_rr_ptr) + i) % REQ_CNT);
        if (!w_any_gnt && req_i[w_idx] && (PRIO0 == 0 || w_idx != '0)) begin
          w_any_gnt = 1'b1;
          w_rr_gnt  = 1'b1;
          w_gnt_idx = w_idx;
        end else begin
          w_any_gnt = w_any_gnt;
        end
      end
    end
    if (w_any_gnt) begin
      w_gnt[w_gnt_idx] = 1'b1;
    end else begin
      w_gnt = '0;
    end
  end

  assign w_gnt_addr = addr_i[w_gnt_idx*A_WIDTH +: A_WIDTH];
  assign w_deny     = |(req_i & ~w_gnt);

  // State: pointer, held address, return pipeline and saturating deny counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= PW'(REQ_CNT - 1);
      r_addr_hold <= '0;
      r_deny_cnt  <= '0;
      for (int s = 0; s < ROM_LATENCY; s++) begin
        r_vld[s] <= '0;
      end
    end else begin
      if (w_any_gnt) begin
        r_addr_hold <= w_gnt_addr;
      end
      if (w_rr_gnt) begin
        r_rr_ptr <= w_gnt_idx;
      end
      r_vld[0] <= w_gnt;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
      if (w_deny && r_deny_cnt != {CNT_WIDTH{1'b1}}) begin
        r_deny_cnt <= r_deny_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign gnt_o      = w_gnt;
  assign rom_addr_o = w_any_gnt ? w_gnt_addr : r_addr_hold;
  // Gate the return strobe so no pulse escapes once reset is asserted
  assign rd_valid_o = rst_n ? r_vld[ROM_LATENCY-1] : '0;
  assign rd_data_o  = rom_data_i;
  assign deny_cnt_o = r_deny_cnt;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench: three arbiter configurations share one stimulus stream, each with its own ROM model.
module tb_font_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [51:0] addr;
  logic [12:0] addrs [4];

  logic [3:0]  gnt1, rv1, gnt2, rv2, gnt3, rv3;
  logic [12:0] ra1, ra2, ra3;
  logic [15:0] rd1, rd2, rd3, rom1, rom2, rom3;
  logic [15:0] dc1, dc3;
  logic [3:0]  dc2;
  logic [12:0] p1, p2a, p2b, p3a, p3b, p3c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] romw(input logic [12:0] a);
    return {a[4:0], a[12:5], 3'b101} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    p1  <= ra1;
    p2a <= ra2;
    p2b <= p2a;
    p3a <= ra3;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign rom1 = romw(p1);
  assign rom2 = romw(p2b);
  assign rom3 = romw(p3c);

  font_rom_arbiter #(.REQ_CNT(4), .A_WIDTH(13), .D_WIDTH(16), .ROM_LATENCY(1), .PRIO0(1), .CNT_WIDTH(16)) d1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt1), .rom_addr_o(ra1),
    .rom_data_i(rom1), .rd_valid_o(rv1), .rd_data_o(rd1), .deny_cnt_o(dc1));

  font_rom_arbiter #(.REQ_CNT(4), .A_WIDTH(13), .D_WIDTH(16), .ROM_LATENCY(2), .PRIO0(0), .CNT_WIDTH(4)) d2 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt2), .rom_addr_o(ra2),
    .rom_data_i(rom2), .rd_valid_o(rv2), .rd_data_o(rd2), .deny_cnt_o(dc2));

  font_rom_arbiter #(.REQ_CNT(4), .A_WIDTH(13), .D_WIDTH(16), .ROM_LATENCY(3), .PRIO0(1), .CNT_WIDTH(16)) d3 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt3), .rom_addr_o(ra3),
    .rom_data_i(rom3), .rd_valid_o(rv3), .rd_data_o(rd3), .deny_cnt_o(dc3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    addrs = '{13'h0041, 13'h0265, 13'h0A65, 13'h1F3F};
    addr  = {addrs[3], addrs[2], addrs[1], addrs[0]};
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();

    // requests during reset: never granted, never counted
    req = 4'b1111;
    #4;
    chk("rst_gnt1", 32'(gnt1), 32'h0);
    chk("rst_gnt2", 32'(gnt2), 32'h0);
    chk("rst_rv1", 32'(rv1), 32'h0);
    tick();
    rst_n = 1'b1;
    req   = 4'b0000;
    #4;
    chk("rst_ra1", 32'(ra1), 32'h0);
    chk("rst_dc1", 32'(dc1), 32'h0);
    chk("rst_dc2", 32'(dc2), 32'h0);
    chk("rst_rv2", 32'(rv2), 32'h0);
    chk("rst_gnt3", 32'(gnt3), 32'h0);

    // single requester, latency 1
    tick();
    req = 4'b0100;
    #4;
    chk("single_gnt", 32'(gnt1), 32'h4);
    chk("single_ra", 32'(ra1), 32'h0A65);
    tick();
    req = 4'b0000;
    #4;
    chk("single_rv", 32'(rv1), 32'h4);
    chk("single_rd", 32'(rd1), 32'(romw(13'h0A65)));
    chk("single_idle_gnt", 32'(gnt1), 32'h0);
    chk("single_hold_ra", 32'(ra1), 32'h0A65);
    chk("single_dc", 32'(dc1), 32'h0);

    // round-robin, all four requesting, latency 2
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      req = 4'b1111;
      #4;
      chk("rr_gnt", 32'(gnt2), 32'(1 << (i % 4)));
      if (i >= 2) begin
        chk("rr_rv", 32'(rv2), 32'(1 << ((i - 2) % 4)));
        chk("rr_rd", 32'(rd2), 32'(romw(addrs[(i - 2) % 4])));
      end else begin
        chk("rr_rv_early", 32'(rv2), 32'h0);
      end
    end
    for (int i = 8; i < 10; i++) begin
      tick();
      req = 4'b0000;
      #4;
      chk("rr_tail_rv", 32'(rv2), 32'(1 << ((i - 2) % 4)));
      chk("rr_tail_rd", 32'(rd2), 32'(romw(addrs[(i - 2) % 4])));
      chk("rr_deny", 32'(dc2), 32'd8);
    end

    // strict priority for requester 0, then round-robin from 1
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      req = (i < 3) ? 4'b1111 : 4'b1110;
      #4;
      chk("prio_gnt", 32'(gnt1), (i < 3) ? 32'h1 : 32'(1 << (((i - 3) % 3) + 1)));
      if (i > 0) begin
        chk("prio_rv", 32'(rv1), (i < 4) ? 32'h1 : 32'(1 << (((i - 4) % 3) + 1)));
      end else begin
        chk("prio_rv0", 32'(rv1), 32'h0);
      end
    end
    tick();
    req = 4'b0000;
    #4;
    chk("prio_last_rv", 32'(rv1), 32'h2);
    chk("prio_deny", 32'(dc1), 32'd7);

    // latency 3, grants to 1,2,3 back to back
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      req = (i < 3) ? 4'b1110 : 4'b0000;
      #4;
      if (i < 3) begin
        chk("lat3_gnt", 32'(gnt3), 32'(1 << (i + 1)));
        chk("lat3_rv_idle", 32'(rv3), 32'h0);
      end else begin
        chk("lat3_rv", 32'(rv3), 32'(1 << (i - 2)));
        chk("lat3_rd", 32'(rd3), 32'(romw(addrs[i - 2])));
      end
    end

    // reset while a latency-2 lookup is in flight
    do_reset();
    tick();
    req = 4'b0100;
    #4;
    chk("mid_gnt", 32'(gnt2), 32'h4);
    chk("mid_ra", 32'(ra2), 32'h0A65);
    tick();
    rst_n = 1'b0;
    req   = 4'b0001;
    #4;
    chk("mid_rst_gnt", 32'(gnt2), 32'h0);
    chk("mid_rst_rv", 32'(rv2), 32'h0);
    tick();
    rst_n = 1'b1;
    req   = 4'b0000;
    #4;
    chk("mid_post_rv", 32'(rv2), 32'h0);
    chk("mid_post_ra", 32'(ra2), 32'h0);
    chk("mid_post_dc", 32'(dc2), 32'h0);
    chk("mid_post_gnt", 32'(gnt2), 32'h0);
    tick();
    req = 4'b1111;
    #4;
    chk("mid_first_gnt", 32'(gnt2), 32'h1);
    chk("mid_first_ra", 32'(ra2), 32'(addrs[0]));
    chk("mid_first_rv", 32'(rv2), 32'h0);

    // 4-bit deny counter saturation with two contenders
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      req = 4'b0011;
      #4;
      chk("sat_dc", 32'(dc2), (i < 15) ? 32'(i) : 32'd15);
      chk("sat_gnt", 32'(gnt2), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    tick();
    req = 4'b0000;
    #4;
    chk("sat_hold", 32'(dc2), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
